rr_bus_arbiter: RTL and testbench

Round-robin arbiter sharing one downstream slave port among NM upstream masters using valid/stall handshaking (READY = !STALL). It sits between the masters and each slave-side address decoder output of the crossbar. It holds a grant for a whole burst until all of that master's outstanding requests have been acknowledged, then routes acknowledgements and errors back to the granted master.

---
 rtl/rr_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NM masters; holds grant per burst, routes ack/err back.
// Latency: grant registered one cycle after request; request, stall and ack/err paths are combinational.
// Backpressure: i_sstall and a full pending counter stall the owner; non-owners are always stalled.
module rr_bus_arbiter #(
   parameter  int NM        = 4,
   parameter  int AW        = 32,
   parameter  int DW        = 38,
   parameter  int LGMAXPEND = 4,
   localparam int LGNM      = $clog2(NM)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NM-1:0]      i_mvalid,
   output logic [NM-1:0]      o_mstall,
   input  logic [NM*AW-1:0]   i_maddr,
   input  logic [NM*DW-1:0]   i_mdata,
   output logic [NM-1:0]      o_mack,
   output logic [NM-1:0]      o_merr,
   output logic               o_svalid,
   input  logic               i_sstall,
   output logic [AW-1:0]      o_saddr,
   output logic [DW-1:0]      o_sdata,
   input  logic               i_sack,
   input  logic               i_serr,
   output logic [LGNM-1:0]    o_owner,
   output logic               o_busy
);

   localparam logic [LGMAXPEND-1:0] MAXPEND = '1;
   localparam logic [LGNM-1:0]      LASTM   = LGNM'(NM - 1);

   typedef enum logic {
      S_IDLE,
      S_GRANTED
   } state_t;

   state_t                 r_state;
   logic [LGNM-1:0]        r_owner;
   logic [LGNM-1:0]        r_rr;
   logic [LGMAXPEND-1:0]   r_pend;

   logic                   w_busy;
   logic                   w_full;
   logic                   w_own_vld;
   logic                   w_accept;
   logic                   w_cmpl;
   logic                   w_found;
   logic [LGNM-1:0]        w_winner;
   logic [LGNM-1:0]        w_cand;
   logic [NM-1:0]          w_sel;

   assign w_busy    = (r_state == S_GRANTED);
   assign w_full    = (r_pend == MAXPEND);
   assign w_own_vld = i_mvalid[r_owner];
   assign w_accept  = o_svalid && !i_sstall;
   // A completion with nothing outstanding is spurious and is dropped here.
   assign w_cmpl    = (i_sack || i_serr) && (r_pend != '0);

   assign o_svalid  = w_busy && w_own_vld && !w_full;
   assign o_owner   = r_owner;
   assign o_busy    = w_busy;

   // Pick the first requester at or after the round-robin pointer, wrapping modulo NM.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = 0; k < NM; k++) begin
         w_cand = LGNM'((int'(r_rr) + k) % NM);
         if (!w_found && i_mvalid[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // Grant state machine: take a grant from IDLE, release once the owner is quiet and drained.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_rr    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_GRANTED;
                  r_owner <= w_winner;
                  r_rr    <= (w_winner == LASTM) ? '0 : w_winner + 1'b1;
               end
            end
            S_GRANTED: begin
               if (!w_own_vld && (r_pend == '0) && !w_accept) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outstanding-request counter; acceptance is blocked at MAXPEND so it never wraps.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pend <= '0;
      end else if (w_accept && !w_cmpl) begin
         r_pend <= r_pend + 1'b1;
      end else if (w_cmpl && !w_accept) begin
         r_pend <= r_pend - 1'b1;
      end
   end

   // One-hot select of the master currently holding the grant.
   always_comb begin
      w_sel = '0;
      for (int m = 0; m < NM; m++) begin
         w_sel[m] = w_busy && (r_owner == LGNM'(m));
      end
   end

   // Request mux, per-master stall and completion routing toward the owner.
   always_comb begin
      o_saddr  = '0;
      o_sdata  = '0;
      o_mstall = '1;
      o_mack   = '0;
      o_merr   = '0;
      for (int m = 0; m < NM; m++) begin
         o_mstall[m] = !w_sel[m] || i_sstall || w_full;
         if (w_sel[m]) begin
            o_saddr = i_maddr[m*AW +: AW];
            o_sdata = i_mdata[m*DW +: DW];
         end
         if (r_owner == LGNM'(m)) begin
            o_mack[m] = w_cmpl && !i_serr;
            o_merr[m] = w_cmpl && i_serr;
         end
      end
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with a 3-deep pending limit.
// Latency: inputs driven 1ns after each rising edge, outputs sampled 1ns later.
// Backpressure: i_sstall driven directly by the stimulus.
module tb_rr_bus_arbiter;

   localparam int NM        = 4;
   localparam int AW        = 32;
   localparam int DW        = 38;
   localparam int LGMAXPEND = 2;
   localparam int LGNM      = 2;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic [NM-1:0]       i_mvalid;
   logic [NM-1:0]       o_mstall;
   logic [NM*AW-1:0]    i_maddr;
   logic [NM*DW-1:0]    i_mdata;
   logic [NM-1:0]       o_mack;
   logic [NM-1:0]       o_merr;
   logic                o_svalid;
   logic                i_sstall;
   logic [AW-1:0]       o_saddr;
   logic [DW-1:0]       o_sdata;
   logic                i_sack;
   logic                i_serr;
   logic [LGNM-1:0]     o_owner;
   logic                o_busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [3:0] seen;
   logic [3:0] pipe;
   logic [3:0] one_hot;
   logic       sv4;
   int         accepts, mack0, mack_other, m1_leak, release_cyc;

   rr_bus_arbiter #(
      .NM(NM), .AW(AW), .DW(DW), .LGMAXPEND(LGMAXPEND)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_mvalid(i_mvalid), .o_mstall(o_mstall),
      .i_maddr(i_maddr), .i_mdata(i_mdata),
      .o_mack(o_mack), .o_merr(o_merr),
      .o_svalid(o_svalid), .i_sstall(i_sstall),
      .o_saddr(o_saddr), .o_sdata(o_sdata),
      .i_sack(i_sack), .i_serr(i_serr),
      .o_owner(o_owner), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      i_reset  = 1'b1;
      i_mvalid = '0;
      i_sstall = 1'b0;
      i_sack   = 1'b0;
      i_serr   = 1'b0;
      for (int m = 0; m < NM; m++) begin
         i_maddr[m*AW +: AW] = 32'hC0DE_0000 + 32'(m) * 32'h11;
         i_mdata[m*DW +: DW] = 38'h2A_0000_0000 + 38'(m) * 38'h101;
      end
      repeat (2) cyc();
      i_reset = 1'b0;
      settle();
      check_eq("rst_busy",   o_busy,   0);
      check_eq("rst_owner",  o_owner,  0);
      check_eq("rst_svalid", o_svalid, 0);
      check_eq("rst_mstall", o_mstall, 4'hF);
      check_eq("rst_mack",   o_mack,   0);
      check_eq("rst_merr",   o_merr,   0);
      check_eq("rst_saddr",  o_saddr,  0);
      check_eq("rst_sdata",  o_sdata,  0);

      // Single master m2, three requests, acks two cycles after each.
      cyc(); i_mvalid = 4'b0100; settle();
      check_eq("t1_c0_svalid", o_svalid, 0);
      cyc(); settle();
      check_eq("t1_busy",   o_busy,   1);
      check_eq("t1_owner",  o_owner,  2);
      check_eq("t1_svalid", o_svalid, 1);
      check_eq("t1_saddr",  o_saddr,  32'hC0DE_0022);
      check_eq("t1_sdata",  o_sdata,  38'h2A_0000_0202);
      check_eq("t1_mstall", o_mstall, 4'b1011);
      cyc(); settle();
      check_eq("t1_c2_svalid", o_svalid, 1);
      check_eq("t1_c2_mack",   o_mack,   0);
      cyc(); i_sack = 1'b1; settle();
      check_eq("t1_c3_mack", o_mack, 4'b0100);
      cyc(); i_mvalid = 4'b0000; settle();
      check_eq("t1_c4_mack",   o_mack,   4'b0100);
      check_eq("t1_c4_svalid", o_svalid, 0);
      cyc(); settle();
      check_eq("t1_c5_mack", o_mack, 4'b0100);
      check_eq("t1_c5_merr", o_merr, 0);
      cyc(); i_sack = 1'b0; settle();
      check_eq("t1_c6_busy", o_busy, 1);
      check_eq("t1_c6_mack", o_mack, 0);
      cyc(); i_mvalid = 4'b1011; settle();
      check_eq("t1_c7_busy", o_busy, 0);
      cyc(); i_mvalid = 4'b0000; settle();
      check_eq("t1_rr_owner", o_owner, 3);
      check_eq("t1_rr_busy",  o_busy,  1);
      cyc(); settle();
      check_eq("t1_c9_busy", o_busy, 0);

      // Contention: all four request, each owner issues one request then steps aside.
      i_mvalid = 4'hF;
      seen = '0;
      for (int g = 0; g < 5; g++) begin
         one_hot = 4'b0001 << exp_order[g];
         cyc(); settle();
         check_eq($sformatf("t2_owner_%0d", g), o_owner, exp_order[g]);
         check_eq($sformatf("t2_stall_%0d", g), o_mstall, 4'hF & ~one_hot);
         if (g < 4) seen = seen | (4'b0001 << o_owner);
         cyc(); i_mvalid = 4'hF & ~one_hot; i_sack = 1'b1; settle();
         check_eq($sformatf("t2_mack_%0d", g), o_mack, one_hot);
         cyc(); i_sack = 1'b0; settle();
         cyc(); i_mvalid = 4'hF; settle();
         check_eq($sformatf("t2_idle_%0d", g), o_busy, 0);
      end
      i_mvalid = 4'h0;
      check_eq("t2_fair", seen, 4'hF);

      // Burst hold: m0 issues five requests, acks four cycles late, m1 waits.
      cyc(); i_mvalid = 4'b0001; settle();
      pipe = '0; accepts = 0; mack0 = 0; mack_other = 0; m1_leak = 0;
      release_cyc = 0; sv4 = 1'b1;
      for (int n = 1; n <= 40 && release_cyc == 0; n++) begin
         cyc();
         i_mvalid = {2'b00, 1'b1, (accepts < 5)};
         i_sack   = pipe[3];
         settle();
         if (!o_busy) begin
            release_cyc = n;
         end else begin
            if (o_mstall[1] !== 1'b1) m1_leak++;
            if (o_mack[0]) mack0++;
            if (o_mack[3:1] != 3'b000) mack_other++;
            if (n == 4) sv4 = o_svalid;
            if (o_svalid && !i_sstall) accepts++;
            pipe = {pipe[2:0], o_svalid && !i_sstall};
         end
      end
      check_eq("t3_release_cyc", release_cyc, 13);
      check_eq("t3_accepts",     accepts,     5);
      check_eq("t3_mack0",       mack0,       5);
      check_eq("t3_mack_other",  mack_other,  0);
      check_eq("t3_m1_stalled",  m1_leak,     0);
      check_eq("t3_sat_svalid",  sv4,         0);
      cyc(); i_sack = 1'b0; i_sstall = 1'b1; settle();
      check_eq("t3_m1_owner",  o_owner,  1);
      check_eq("t3_m1_svalid", o_svalid, 1);
      check_eq("t3_m1_sstall", o_mstall, 4'hF);
      cyc(); i_mvalid = 4'b0000; i_sstall = 1'b0; settle();
      cyc(); settle();
      check_eq("t3_end_busy", o_busy, 0);

      // Saturation at MAXPEND=3 with no acks, then reset mid-burst.
      cyc(); i_mvalid = 4'b0100; settle();
      cyc(); settle();
      check_eq("t4_acc1", o_svalid, 1);
      cyc(); settle();
      cyc(); settle();
      check_eq("t4_acc3", o_svalid, 1);
      cyc(); settle();
      check_eq("t4_full_svalid", o_svalid, 0);
      check_eq("t4_full_mstall", o_mstall, 4'hF);
      cyc(); i_sack = 1'b1; settle();
      check_eq("t4_free_mack",   o_mack,   4'b0100);
      check_eq("t4_free_svalid", o_svalid, 0);
      cyc(); i_sack = 1'b0; settle();
      check_eq("t4_one_svalid", o_svalid, 1);
      check_eq("t4_one_mstall", o_mstall, 4'b1011);
      cyc(); settle();
      check_eq("t4_refull_svalid", o_svalid, 0);
      i_reset = 1'b1;
      cyc(); i_reset = 1'b0; i_mvalid = 4'b0000; settle();
      check_eq("t4_rst_busy",   o_busy,   0);
      check_eq("t4_rst_mstall", o_mstall, 4'hF);
      check_eq("t4_rst_svalid", o_svalid, 0);
      cyc(); i_sack = 1'b1; settle();
      check_eq("t4_late_mack", o_mack, 0);
      check_eq("t4_late_merr", o_merr, 0);
      cyc(); i_sack = 1'b0; i_mvalid = 4'b0100; settle();
      cyc(); settle();
      check_eq("t4_regrant_owner",  o_owner,  2);
      check_eq("t4_regrant_svalid", o_svalid, 1);

      // Error completion (err wins over ack), then spurious acks.
      cyc(); i_mvalid = 4'b0000; i_serr = 1'b1; i_sack = 1'b1; settle();
      check_eq("t5_merr", o_merr, 4'b0100);
      check_eq("t5_mack", o_mack, 0);
      cyc(); i_serr = 1'b0; settle();
      check_eq("t5_spur_mack", o_mack, 0);
      check_eq("t5_spur_merr", o_merr, 0);
      check_eq("t5_spur_busy", o_busy, 1);
      cyc(); settle();
      check_eq("t5_idle_busy", o_busy, 0);
      check_eq("t5_idle_mack", o_mack, 0);
      cyc(); i_sack = 1'b0; settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
